// File: rtl/custom_ip_regif.sv
// Register interface between a simple req/gnt bus and a three-channel IP:
// acknowledged write strobes with timeout, and captured read words with status flags.
module custom_ip_regif #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned DATA_WIDTH = 96
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [4:0]            addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] reg2ip_data_o,
  output logic [2:0]            reg2ip_en_o,
  input  logic [2:0]            reg2ip_ack_i,
  input  logic [DATA_WIDTH+2:0] ip2reg_data_i,
  input  logic [2:0]            ip2reg_en_i
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ch_state_e;

  logic [2:0]       widx;
  logic             unused_addr;
  logic [2:0]       wr_sel;
  logic [2:0]       rd_sel;
  logic [2:0]       pending;
  logic [2:0]       flag;
  logic [2:0]       fbit;
  logic [2:0]       sticky;
  logic [2:0][31:0] wr_word;
  logic [2:0][31:0] rd_word;
  logic             status_wr;
  logic [31:0]      status;
  logic [31:0]      resp_data;
  logic             resp_err;
  logic             rvalid_reg;
  logic [31:0]      rdata_reg;
  logic             err_reg;

  assign widx        = addr_i[4:2];
  assign unused_addr = ^addr_i[1:0];

  // A write to a channel that is still waiting for its acknowledge is stalled.
  assign gnt_o     = req_i & ~(we_i & |(wr_sel & pending));
  assign status_wr = gnt_o & we_i & (widx == 3'd6);
  assign status    = {20'd0, sticky, fbit, flag, pending};

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    ch_state_e     state_reg;
    ch_state_e     state_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [31:0]   wr_reg;
    logic [31:0]   rd_reg;
    logic          start;
    logic          rd_hit;
    logic          timeout_hit;
    logic          sticky_reg;
    logic          flag_reg;
    logic          f_reg;

    assign wr_sel[gi] = (widx == 3'(gi));
    assign rd_sel[gi] = (widx == 3'(gi + 3));
    assign start      = gnt_o & we_i & wr_sel[gi];
    assign rd_hit     = gnt_o & ~we_i & rd_sel[gi];

    always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      timeout_hit = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_next = ST_BUSY;
            cnt_next   = '0;
          end
        end
        ST_BUSY: begin
          cnt_next = cnt_reg + CW'(1);
          if (reg2ip_ack_i[gi]) begin
            state_next = ST_IDLE;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            state_next  = ST_IDLE;
            timeout_hit = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_reg  <= ST_IDLE;
        cnt_reg    <= '0;
        wr_reg     <= '0;
        sticky_reg <= 1'b0;
      end else begin
        state_reg  <= state_next;
        cnt_reg    <= cnt_next;
        if (start) wr_reg <= wdata_i;
        // A timeout in the same cycle as a clearing write keeps the bit set.
        sticky_reg <= (sticky_reg & ~(status_wr & wdata_i[9+gi])) | timeout_hit;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rd_reg   <= '0;
        f_reg    <= 1'b0;
        flag_reg <= 1'b0;
      end else if (ip2reg_en_i[gi]) begin
        rd_reg   <= ip2reg_data_i[DATA_WIDTH+2-33*gi -: 32];
        f_reg    <= ip2reg_data_i[DATA_WIDTH+2-33*gi-32];
        flag_reg <= 1'b1;
      end else if (rd_hit) begin
        flag_reg <= 1'b0;
      end
    end

    assign pending[gi]                               = (state_reg == ST_BUSY);
    assign reg2ip_en_o[gi]                           = (state_reg == ST_BUSY);
    assign reg2ip_data_o[DATA_WIDTH-1-32*gi -: 32]   = wr_reg;
    assign wr_word[gi]                               = wr_reg;
    assign rd_word[gi]                               = rd_reg;
    assign flag[gi]                                  = flag_reg;
    assign fbit[gi]                                  = f_reg;
    assign sticky[gi]                                = sticky_reg;
  end

  always_comb begin
    resp_data = '0;
    resp_err  = 1'b0;
    case (widx)
      3'd0: if (!we_i) resp_data = wr_word[0];
      3'd1: if (!we_i) resp_data = wr_word[1];
      3'd2: if (!we_i) resp_data = wr_word[2];
      3'd3: if (!we_i) resp_data = rd_word[0];
      3'd4: if (!we_i) resp_data = rd_word[1];
      3'd5: if (!we_i) resp_data = rd_word[2];
      3'd6: if (!we_i) resp_data = status;
      default: resp_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      rvalid_reg <= gnt_o;
      rdata_reg  <= gnt_o ? resp_data : 32'd0;
      err_reg    <= gnt_o & resp_err;
    end
  end

  assign rvalid_o = rvalid_reg;
  assign rdata_o  = rdata_reg;
  assign err_o    = err_reg;

endmodule

// File: tb/tb_custom_ip_regif.sv
// Directed bench for custom_ip_regif; responses are checked by a queue-based scoreboard.
module tb_custom_ip_regif;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [4:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [95:0] reg2ip_data_o;
  logic [2:0]  reg2ip_en_o;
  logic [2:0]  reg2ip_ack_i = '0;
  logic [98:0] ip2reg_data_i = '0;
  logic [2:0]  ip2reg_en_i = '0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];
  string       name_q[$];

  custom_ip_regif #(.TIMEOUT(16), .DATA_WIDTH(96)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .we_i          (we_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .reg2ip_data_o (reg2ip_data_o),
    .reg2ip_en_o   (reg2ip_en_o),
    .reg2ip_ack_i  (reg2ip_ack_i),
    .ip2reg_data_i (ip2reg_data_i),
    .ip2reg_en_i   (ip2reg_en_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one bus request, hold it until granted, and queue the expected response.
  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee, input string nm);
    int n;
    n = 0;
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
    #1;
    while (gnt_o !== 1'b1 && n < 40) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (gnt_o !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_gnt: got gnt_o=0 for 40 cycles, required 1", nm);
      req_i = 1'b0; we_i = 1'b0;
      return;
    end
    exp_q.push_back({ee, er});
    name_q.push_back(nm);
    @(posedge clk_i);
    #1;
    req_i = 1'b0; we_i = 1'b0;
    check({nm, "_rvalid"}, 128'(rvalid_o), 128'd1);
  endtask

  task automatic cap(input logic [2:0] en, input logic [98:0] d);
    ip2reg_data_i = d;
    ip2reg_en_i   = en;
    tick();
    ip2reg_en_i   = '0;
  endtask

  always @(negedge clk_i) begin
    logic [32:0] e;
    string       nm;
    if (rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got rvalid with rdata 0x%0h, required no response", rdata_o);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        $display("rsp %s rdata=0x%08h err=%0b", nm, rdata_o, err_o);
        check(nm, 128'({err_o, rdata_o}), 128'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_rvalid", 128'(rvalid_o), 128'd0);
    check("rst_rdata", 128'(rdata_o), 128'd0);
    check("rst_err", 128'(err_o), 128'd0);
    check("rst_en", 128'(reg2ip_en_o), 128'd0);
    check("rst_data", 128'(reg2ip_data_o), 128'd0);
    rst_ni = 1'b1;
    tick();

    // Write WR1, acknowledge in the third strobe cycle
    bus(1'b1, 5'h04, 32'hDEADBEEF, 32'd0, 1'b0, "wr1");
    check("wr1_en_c1", 128'(reg2ip_en_o), 128'b010);
    check("wr1_data", 128'(reg2ip_data_o[63:32]), 128'hDEADBEEF);
    bus(1'b0, 5'h18, 32'd0, 32'h2, 1'b0, "status_pend1");
    check("wr1_en_c2", 128'(reg2ip_en_o[1]), 128'd1);
    tick();
    reg2ip_ack_i = 3'b010;
    check("wr1_en_c3", 128'(reg2ip_en_o[1]), 128'd1);
    tick();
    reg2ip_ack_i = 3'b000;
    check("wr1_en_done", 128'(reg2ip_en_o), 128'd0);
    bus(1'b0, 5'h18, 32'd0, 32'h0, 1'b0, "status_idle1");
    bus(1'b0, 5'h04, 32'd0, 32'hDEADBEEF, 1'b0, "rd_wr1");

    // Write WR0 with no acknowledge: times out after 16 strobe cycles
    bus(1'b1, 5'h00, 32'h11112222, 32'd0, 1'b0, "wr0");
    check("wr0_data", 128'(reg2ip_data_o[95:64]), 128'h11112222);
    n = 0;
    while (reg2ip_en_o[0] === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("wr0_en_cycles", 128'(n), 128'd16);
    bus(1'b0, 5'h18, 32'd0, 32'h200, 1'b0, "status_sticky0");
    bus(1'b1, 5'h18, 32'h200, 32'd0, 1'b0, "status_clr");
    bus(1'b0, 5'h18, 32'd0, 32'h0, 1'b0, "status_cleared");
    bus(1'b0, 5'h00, 32'd0, 32'h11112222, 1'b0, "rd_wr0");

    // Second write to WR2 stalls until the first is acknowledged
    bus(1'b1, 5'h08, 32'hA0A0A0A0, 32'd0, 1'b0, "wr2_a");
    fork
      bus(1'b1, 5'h08, 32'hB1B1B1B1, 32'd0, 1'b0, "wr2_b");
      begin
        tick();
        check("wr2_stall_gnt", 128'(gnt_o), 128'd0);
        tick();
        check("wr2_stall_data", 128'(reg2ip_data_o[31:0]), 128'hA0A0A0A0);
        reg2ip_ack_i = 3'b100;
        tick();
        reg2ip_ack_i = 3'b000;
        check("wr2_en_gap", 128'(reg2ip_en_o[2]), 128'd0);
      end
    join
    check("wr2_b_en", 128'(reg2ip_en_o[2]), 128'd1);
    check("wr2_b_data", 128'(reg2ip_data_o[31:0]), 128'hB1B1B1B1);
    reg2ip_ack_i = 3'b100;
    tick();
    reg2ip_ack_i = 3'b000;
    check("wr2_b_done", 128'(reg2ip_en_o[2]), 128'd0);

    // Read captures
    cap(3'b001, {32'h2468, 1'b1, 66'd0});
    bus(1'b0, 5'h18, 32'd0, 32'h48, 1'b0, "status_cap0");
    bus(1'b0, 5'h0C, 32'd0, 32'h2468, 1'b0, "rd0");
    bus(1'b0, 5'h18, 32'd0, 32'h40, 1'b0, "status_rd0");
    ip2reg_data_i = {32'h1357, 1'b0, 66'd0};
    ip2reg_en_i   = 3'b001;
    bus(1'b0, 5'h0C, 32'd0, 32'h2468, 1'b0, "rd0_collide");
    ip2reg_en_i   = 3'b000;
    bus(1'b0, 5'h18, 32'd0, 32'h08, 1'b0, "status_collide");
    bus(1'b0, 5'h0C, 32'd0, 32'h1357, 1'b0, "rd0_new");
    bus(1'b1, 5'h0C, 32'hFFFF, 32'd0, 1'b0, "wr_ro_rd0");
    bus(1'b0, 5'h0C, 32'd0, 32'h1357, 1'b0, "rd0_kept");
    cap(3'b010, {33'd0, 32'hCAFE0001, 1'b1, 33'd0});
    bus(1'b0, 5'h18, 32'd0, 32'h90, 1'b0, "status_cap1");
    bus(1'b0, 5'h10, 32'd0, 32'hCAFE0001, 1'b0, "rd1");
    bus(1'b1, 5'h18, 32'hFFFFF1FF, 32'd0, 1'b0, "status_ro_wr");
    bus(1'b0, 5'h18, 32'd0, 32'h80, 1'b0, "status_rd1");

    // Unmapped address
    bus(1'b0, 5'h1C, 32'd0, 32'd0, 1'b1, "rd_unmapped");
    bus(1'b1, 5'h1C, 32'h1234, 32'd0, 1'b1, "wr_unmapped");

    // Reset during BUSY
    bus(1'b1, 5'h04, 32'h55, 32'd0, 1'b0, "wr1_rst");
    check("rst_busy_en_pre", 128'(reg2ip_en_o[1]), 128'd1);
    rst_ni = 1'b0;
    tick();
    check("rst_busy_en", 128'(reg2ip_en_o), 128'd0);
    check("rst_busy_data", 128'(reg2ip_data_o), 128'd0);
    check("rst_busy_rvalid", 128'(rvalid_o), 128'd0);
    rst_ni = 1'b1;
    repeat (20) tick();
    bus(1'b0, 5'h18, 32'd0, 32'h0, 1'b0, "status_after_rst");

    repeat (3) tick();
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
